// File: rtl/mo_pkg.sv
// Shared constants and helpers for the motion-object pixel serializer.
package mo_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam int BPP_DEF   = 3;
  localparam int PIX_DEF   = 4;
  localparam int PIC_W_DEF = 8;
  localparam int ROW_W_DEF = 5;

  // All-ones pattern of width n (the transparent pixel value); callers slice the low n bits.
  function automatic logic [63:0] transparent(input int unsigned n);
    if (n >= 64) return '1;
    return (64'd1 << n) - 64'd1;
  endfunction

endpackage

// File: rtl/mo_plane_shifter.sv
// One bit-plane: PIX-bit universal shift register with parallel load and a fill bit.
module mo_plane_shifter #(
  parameter int PIX = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ld,
  input  logic [PIX-1:0] ld_val,
  input  logic           sh_en,
  input  logic           sh_up,
  input  logic           fill,
  output logic [PIX-1:0] q
);

  logic [PIX-1:0] sr_q;
  logic [PIX-1:0] sr_d;
  logic [PIX-1:0] up_v;
  logic [PIX-1:0] dn_v;

  always_comb begin
    up_v = sr_q;
    dn_v = sr_q;
    up_v[0] = fill;
    for (int i = 1; i < PIX; i++) up_v[i] = sr_q[i-1];
    dn_v[PIX-1] = fill;
    for (int i = 0; i < PIX-1; i++) dn_v[i] = sr_q[i+1];

    sr_d = sr_q;
    if (ld)         sr_d = ld_val;
    else if (sh_en) sr_d = sh_up ? up_v : dn_v;
  end

  always_ff @(posedge clk) begin
    if (reset) sr_q <= '1;
    else       sr_q <= sr_d;
  end

  assign q = sr_q;

endmodule

// File: rtl/mo_pixel_serializer.sv
// Motion-object pixel serializer: picture latch, ROM word prefetch buffer and BPP plane shifters
// with manual and auto (self-counting, seamless reload) modes.
module mo_pixel_serializer
  import mo_pkg::*;
#(
  parameter int BPP   = BPP_DEF,
  parameter int PIX   = PIX_DEF,
  parameter int PIC_W = PIC_W_DEF,
  parameter int ROW_W = ROW_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce_pix,
  input  logic                   ce_fetch,
  input  logic                   pic_ld,
  input  logic [PIC_W-1:0]       pic_in,
  input  logic [ROW_W-1:0]       row_in,
  input  logic                   match_n,
  input  logic [1:0]             mode,
  input  logic                   auto_en,
  input  logic                   flip,
  output logic [PIC_W+ROW_W-1:0] rom_addr,
  input  logic [BPP*PIX-1:0]     rom_data,
  output logic [BPP-1:0]         pix,
  output logic                   pix_opaque,
  output logic                   need_fetch,
  output logic                   underrun
);

  localparam int ADDR_W = PIC_W + ROW_W;
  localparam int WORD_W = BPP * PIX;
  localparam int CNT_W  = (PIX > 1) ? $clog2(PIX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIX - 1);
  localparam logic [63:0]      PIX_ONES = transparent(BPP);

  logic [PIC_W-1:0]  pic_q, pic_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic              buf_valid_q, buf_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              underrun_q, underrun_d;
  logic              auto_q, auto_d;

  logic [WORD_W-1:0] masked_word;
  logic [WORD_W-1:0] ld_word;
  logic [CNT_W-1:0]  cnt_eff;
  logic              sr_ld, sh_en, sh_up, fill;
  logic              consume, bypass_empty;
  logic [PIX-1:0]    sr [BPP];

  assign masked_word = match_n ? '1 : rom_data;

  always_comb begin
    pic_d        = (ce_fetch && pic_ld) ? pic_in : pic_q;
    buf_d        = ce_fetch ? masked_word : buf_q;
    cnt_eff      = (auto_en != auto_q) ? '0 : cnt_q;
    cnt_d        = cnt_eff;
    underrun_d   = underrun_q;
    auto_d       = auto_en;
    sr_ld        = 1'b0;
    ld_word      = buf_q;
    sh_en        = 1'b0;
    sh_up        = 1'b1;
    fill         = 1'b0;
    consume      = 1'b0;
    bypass_empty = 1'b0;

    if (ce_pix) begin
      if (!auto_en) begin
        case (mode)
          MODE_SHL: begin sh_en = 1'b1; sh_up = 1'b1; end
          MODE_SHR: begin sh_en = 1'b1; sh_up = 1'b0; end
          MODE_LOAD: begin
            sr_ld   = 1'b1;
            ld_word = ce_fetch ? masked_word : buf_q;
            consume = 1'b1;
          end
          default: ;
        endcase
      end else begin
        fill  = 1'b1;
        cnt_d = (cnt_eff == CNT_LAST) ? '0 : cnt_eff + CNT_W'(1);
        if (cnt_eff == CNT_LAST) begin
          // Reload slot: buffered word first, then same-cycle bypass, else transparent + underrun.
          sr_ld = 1'b1;
          if (buf_valid_q) begin
            ld_word = buf_q;
            consume = 1'b1;
          end else if (ce_fetch) begin
            ld_word      = masked_word;
            consume      = 1'b1;
            bypass_empty = 1'b1;
          end else begin
            ld_word    = '1;
            underrun_d = 1'b1;
          end
        end else begin
          sh_en = 1'b1;
          sh_up = ~flip;
        end
      end
    end

    if (ce_fetch && !bypass_empty) buf_valid_d = 1'b1;
    else if (consume)              buf_valid_d = 1'b0;
    else                           buf_valid_d = buf_valid_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pic_q       <= '0;
      buf_q       <= '1;
      buf_valid_q <= 1'b0;
      cnt_q       <= '0;
      underrun_q  <= 1'b0;
      auto_q      <= 1'b0;
    end else begin
      pic_q       <= pic_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      cnt_q       <= cnt_d;
      underrun_q  <= underrun_d;
      auto_q      <= auto_d;
    end
  end

  for (genvar p = 0; p < BPP; p++) begin : g_plane
    mo_plane_shifter #(.PIX(PIX)) u_plane (
      .clk    (clk),
      .reset  (reset),
      .ld     (sr_ld),
      .ld_val (ld_word[p*PIX +: PIX]),
      .sh_en  (sh_en),
      .sh_up  (sh_up),
      .fill   (fill),
      .q      (sr[p])
    );
    assign pix[p] = flip ? sr[p][0] : sr[p][PIX-1];
  end

  assign rom_addr   = ADDR_W'({pic_q, row_in});
  assign pix_opaque = (pix != PIX_ONES[BPP-1:0]);
  assign need_fetch = auto_en & ~buf_valid_q;
  assign underrun   = underrun_q;

endmodule
